// File: rtl/alu_if.sv
// Operand/result bundle for the registered ALU.
// master drives operands, slave (the ALU) returns result and flags.
interface alu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opcode;
    logic        mode;
    logic [63:0] outALU;
    logic        za;
    logic        zb;
    logic        eq;
    logic        gt;
    logic        lt;

    modport master (
        output a,
        output b,
        output opcode,
        output mode,
        input  outALU,
        input  za,
        input  zb,
        input  eq,
        input  gt,
        input  lt
    );

    modport slave (
        input  a,
        input  b,
        input  opcode,
        input  mode,
        output outALU,
        output za,
        output zb,
        output eq,
        output gt,
        output lt
    );
endinterface

// File: rtl/alu.sv
// Single-stage 32-bit ALU with 64-bit registered result.
// Mode 0 arithmetic, mode 1 logic/compare; flags track a and b.
module alu (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;

    logic [63:0] a_x;
    logic [63:0] b_x;
    logic [63:0] sum;
    logic [63:0] prod;
    logic [63:0] diff;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        a_eq_b;
    logic        a_gt_b;
    logic        a_lt_b;
    logic [63:0] arith_res;
    logic [63:0] logic_res;
    logic [63:0] res;

    assign a_x = {32'b0, bus.a};
    assign b_x = {32'b0, bus.b};

    assign sum  = a_x + b_x;
    assign prod = a_x * b_x;
    assign diff = a_x - b_x;

    assign a_eq_b = (bus.a == bus.b);
    assign a_gt_b = (bus.a > bus.b);
    assign a_lt_b = (bus.a < bus.b);

    // Divide by zero yields all-ones quotient and passes a through.
    always_comb begin
        quo = 32'hFFFF_FFFF;
        rem = bus.a;
        if (bus.b != 32'b0) begin
            quo = bus.a / bus.b;
            rem = bus.a % bus.b;
        end
    end

    // Arithmetic result select; unused codes give zero.
    always_comb begin
        arith_res = 64'b0;
        case (bus.opcode)
            OP_ADD:  arith_res = sum;
            OP_MUL:  arith_res = prod;
            OP_SUB:  arith_res = diff;
            OP_DIV:  arith_res = {rem, quo};
            default: arith_res = 64'b0;
        endcase
    end

    // Logic/compare result select; unused code gives zero.
    always_comb begin
        logic_res = 64'b0;
        case (bus.opcode)
            OP_AND:  logic_res = {32'b0, bus.a & bus.b};
            OP_OR:   logic_res = {32'b0, bus.a | bus.b};
            OP_XOR:  logic_res = {32'b0, bus.a ^ bus.b};
            OP_NOT:  logic_res = {32'b0, ~bus.a};
            OP_EQ:   logic_res = {63'b0, a_eq_b};
            OP_GT:   logic_res = {63'b0, a_gt_b};
            OP_LT:   logic_res = {63'b0, a_lt_b};
            default: logic_res = 64'b0;
        endcase
    end

    assign res = bus.mode ? logic_res : arith_res;

    // Capture result and flags each cycle; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.outALU <= 64'b0;
            bus.za     <= 1'b0;
            bus.zb     <= 1'b0;
            bus.eq     <= 1'b0;
            bus.gt     <= 1'b0;
            bus.lt     <= 1'b0;
        end else begin
            bus.outALU <= res;
            bus.za     <= (bus.a == 32'b0);
            bus.zb     <= (bus.b == 32'b0);
            bus.eq     <= a_eq_b;
            bus.gt     <= a_gt_b;
            bus.lt     <= a_lt_b;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for the registered ALU.
// Flags are compared as {za, zb, eq, gt, lt}.
module tb_alu;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nbad;

    alu_if bus ();

    alu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [2:0]  op;
        logic [63:0] r;
        logic [4:0]  f;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] flags();
        return {bus.za, bus.zb, bus.eq, bus.gt, bus.lt};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic [2:0] op);
        @(negedge clk);
        bus.a      = a;
        bus.b      = b;
        bus.mode   = m;
        bus.opcode = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.a      = 32'd5;
        bus.b      = 32'd3;
        bus.mode   = 1'b0;
        bus.opcode = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (bus.outALU !== 64'd0) begin
            nbad++;
            $display("FAIL reset outALU got %h want 0", bus.outALU);
        end
        nvec++;
        if (flags() !== 5'b00000) begin
            nbad++;
            $display("FAIL reset flags got %b want 00000", flags());
        end
        @(negedge clk);
        bus.a = 32'd0;
        bus.b = 32'd0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nvec++;
        if (bus.outALU !== 64'd0) begin
            nbad++;
            $display("FAIL rel outALU got %h want 0", bus.outALU);
        end
        nvec++;
        if (flags() !== 5'b11100) begin
            nbad++;
            $display("FAIL rel flags got %b want 11100", flags());
        end
    endtask

    task automatic test_arith();
        vec_t v[6];
        v = '{
            '{32'd5, 32'd3, 1'b0, 3'd0, 64'd8, 5'b00010},
            '{32'hFFFF_FFFF, 32'd1, 1'b0, 3'd0,
              64'h1_0000_0000, 5'b00010},
            '{32'd2, 32'd4, 1'b0, 3'd1, 64'd8, 5'b00001},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'd1,
              64'hFFFF_FFFE_0000_0001, 5'b00100},
            '{32'd7, 32'd2, 1'b0, 3'd2, 64'd5, 5'b00010},
            '{32'd2, 32'd7, 1'b0, 3'd2,
              64'hFFFF_FFFF_FFFF_FFFB, 5'b00001}
        };
        for (int i = 0; i < 6; i++) begin
            drive(v[i].a, v[i].b, v[i].m, v[i].op);
            nvec++;
            if (bus.outALU !== v[i].r) begin
                nbad++;
                $display("FAIL arith[%0d] outALU got %h want %h",
                         i, bus.outALU, v[i].r);
            end
            nvec++;
            if (flags() !== v[i].f) begin
                nbad++;
                $display("FAIL arith[%0d] flags got %b want %b",
                         i, flags(), v[i].f);
            end
        end
    endtask

    task automatic test_div();
        vec_t v[4];
        v = '{
            '{32'd8, 32'd2, 1'b0, 3'd3,
              64'h0000_0000_0000_0004, 5'b00010},
            '{32'd2, 32'd8, 1'b0, 3'd3,
              64'h0000_0002_0000_0000, 5'b00001},
            '{32'd8, 32'd0, 1'b0, 3'd3,
              64'h0000_0008_FFFF_FFFF, 5'b01010},
            '{32'd0, 32'd0, 1'b0, 3'd3,
              64'h0000_0000_FFFF_FFFF, 5'b11100}
        };
        for (int i = 0; i < 4; i++) begin
            drive(v[i].a, v[i].b, v[i].m, v[i].op);
            nvec++;
            if (bus.outALU !== v[i].r) begin
                nbad++;
                $display("FAIL div[%0d] outALU got %h want %h",
                         i, bus.outALU, v[i].r);
            end
            nvec++;
            if (flags() !== v[i].f) begin
                nbad++;
                $display("FAIL div[%0d] flags got %b want %b",
                         i, flags(), v[i].f);
            end
        end
    endtask

    task automatic test_logic();
        vec_t v[5];
        v = '{
            '{32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 3'd0,
              64'h0000_0000_0000_FFFF, 5'b00010},
            '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 3'd1,
              64'h0000_0000_FFFF_FFFF, 5'b00001},
            '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 3'd2,
              64'h0000_0000_FFFF_FFFF, 5'b00010},
            '{32'hFFFF_FFFF, 32'd0, 1'b1, 3'd3, 64'd0, 5'b01010},
            '{32'd0, 32'd123, 1'b1, 3'd3,
              64'h0000_0000_FFFF_FFFF, 5'b10001}
        };
        for (int i = 0; i < 5; i++) begin
            drive(v[i].a, v[i].b, v[i].m, v[i].op);
            nvec++;
            if (bus.outALU !== v[i].r) begin
                nbad++;
                $display("FAIL logic[%0d] outALU got %h want %h",
                         i, bus.outALU, v[i].r);
            end
            nvec++;
            if (flags() !== v[i].f) begin
                nbad++;
                $display("FAIL logic[%0d] flags got %b want %b",
                         i, flags(), v[i].f);
            end
        end
    endtask

    task automatic test_compare();
        vec_t v[6];
        v = '{
            '{32'd5, 32'd5, 1'b1, 3'd4, 64'd1, 5'b00100},
            '{32'd7, 32'd5, 1'b1, 3'd5, 64'd1, 5'b00010},
            '{32'd3, 32'd5, 1'b1, 3'd6, 64'd1, 5'b00001},
            '{32'd3, 32'd5, 1'b1, 3'd5, 64'd0, 5'b00001},
            '{32'd3, 32'd5, 1'b1, 3'd4, 64'd0, 5'b00001},
            '{32'd9, 32'd5, 1'b1, 3'd6, 64'd0, 5'b00010}
        };
        for (int i = 0; i < 6; i++) begin
            drive(v[i].a, v[i].b, v[i].m, v[i].op);
            nvec++;
            if (bus.outALU !== v[i].r) begin
                nbad++;
                $display("FAIL cmp[%0d] outALU got %h want %h",
                         i, bus.outALU, v[i].r);
            end
            nvec++;
            if (flags() !== v[i].f) begin
                nbad++;
                $display("FAIL cmp[%0d] flags got %b want %b",
                         i, flags(), v[i].f);
            end
        end
    endtask

    task automatic test_unused();
        vec_t v[5];
        v = '{
            '{32'd9, 32'd4, 1'b0, 3'd4, 64'd0, 5'b00010},
            '{32'd1, 32'd4, 1'b0, 3'd5, 64'd0, 5'b00001},
            '{32'd6, 32'd6, 1'b0, 3'd6, 64'd0, 5'b00100},
            '{32'd0, 32'd4, 1'b0, 3'd7, 64'd0, 5'b10001},
            '{32'd0, 32'd0, 1'b1, 3'd7, 64'd0, 5'b11100}
        };
        for (int i = 0; i < 5; i++) begin
            drive(v[i].a, v[i].b, v[i].m, v[i].op);
            nvec++;
            if (bus.outALU !== v[i].r) begin
                nbad++;
                $display("FAIL unused[%0d] outALU got %h want %h",
                         i, bus.outALU, v[i].r);
            end
            nvec++;
            if (flags() !== v[i].f) begin
                nbad++;
                $display("FAIL unused[%0d] flags got %b want %b",
                         i, flags(), v[i].f);
            end
        end
    endtask

    task automatic test_latency();
        drive(32'd1, 32'd2, 1'b0, 3'd0);
        nvec++;
        if (bus.outALU !== 64'd3) begin
            nbad++;
            $display("FAIL lat0 outALU got %h want 3", bus.outALU);
        end
        #2;
        bus.a = 32'd10;
        #1;
        nvec++;
        if (bus.outALU !== 64'd3) begin
            nbad++;
            $display("FAIL lat_hold outALU got %h want 3", bus.outALU);
        end
        nvec++;
        if (flags() !== 5'b00001) begin
            nbad++;
            $display("FAIL lat_hold flags got %b want 00001", flags());
        end
        @(posedge clk);
        #1;
        nvec++;
        if (bus.outALU !== 64'd12) begin
            nbad++;
            $display("FAIL lat1 outALU got %h want c", bus.outALU);
        end
        nvec++;
        if (flags() !== 5'b00010) begin
            nbad++;
            $display("FAIL lat1 flags got %b want 00010", flags());
        end
    endtask

    task automatic test_mid_reset();
        drive(32'd5, 32'd3, 1'b0, 3'd1);
        nvec++;
        if (bus.outALU !== 64'd15) begin
            nbad++;
            $display("FAIL mrst0 outALU got %h want f", bus.outALU);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.outALU !== 64'd0) begin
            nbad++;
            $display("FAIL mrst outALU got %h want 0", bus.outALU);
        end
        nvec++;
        if (flags() !== 5'b00000) begin
            nbad++;
            $display("FAIL mrst flags got %b want 00000", flags());
        end
        @(negedge clk);
        rst_n      = 1'b1;
        bus.a      = 32'd4;
        bus.b      = 32'd4;
        bus.mode   = 1'b0;
        bus.opcode = 3'd0;
        @(posedge clk);
        #1;
        nvec++;
        if (bus.outALU !== 64'd8) begin
            nbad++;
            $display("FAIL mrst1 outALU got %h want 8", bus.outALU);
        end
        nvec++;
        if (flags() !== 5'b00100) begin
            nbad++;
            $display("FAIL mrst1 flags got %b want 00100", flags());
        end
    endtask

    initial begin
        nvec = 0;
        nbad = 0;
        test_reset();
        test_arith();
        test_div();
        test_logic();
        test_compare();
        test_unused();
        test_latency();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
